// File: rtl/cpu_control_rtype.sv
// Single-cycle R-type CPU core: PC, instruction ROM (IM), 32x32 register bank (BR), ALU.
// Build option: define CPU_SHIFT_EN to add sll/srl/sra decoding.

module cpu_control_rtype_im #(
   parameter int IM_DEPTH = 64,
   parameter int AW       = $clog2(IM_DEPTH)
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_addr,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_inst
);
   reg [31:0] instBank [0:IM_DEPTH-1];

   // Contents normally come from a hierarchical preload; the write port is a load hook tied off at the top.
   always_ff @(posedge i_clk) begin
      if (i_we)
         instBank[i_waddr] <= i_wdata;
   end

   assign o_inst = instBank[i_addr];
endmodule

module cpu_control_rtype_br (
   input  logic        i_clk,
   input  logic        i_we,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_a,
   output logic [31:0] o_b
);
   reg [31:0] registerBank [0:31];

   always_ff @(posedge i_clk) begin
      if (i_we && (i_rd != 5'd0))
         registerBank[i_rd] <= i_wdata;
   end

   // Entry 0 is never trusted: preloaded contents there must still read as zero.
   assign o_a = (i_rs == 5'd0) ? 32'd0 : registerBank[i_rs];
   assign o_b = (i_rt == 5'd0) ? 32'd0 : registerBank[i_rt];
endmodule

module cpu_control_rtype #(
   parameter int IM_DEPTH = 64
) (
   input  logic        clk_CPU,
   input  logic        reset_CPU,
   output logic [31:0] resultado
);
   localparam int AW = $clog2(IM_DEPTH);

   logic [31:0] r_pc;
   logic [31:0] w_inst;
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [31:0] w_alu;
   logic        w_supported;
   logic        w_reg_write;
   logic [5:0]  w_op;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_shamt;
   logic [5:0]  w_funct;

   always_ff @(posedge clk_CPU or posedge reset_CPU) begin
      if (reset_CPU)
         r_pc <= 32'd0;
      else
         r_pc <= r_pc + 32'd4;
   end

   cpu_control_rtype_im #(.IM_DEPTH(IM_DEPTH), .AW(AW)) IM (
      .i_clk   (clk_CPU),
      .i_addr  (r_pc[AW+1:2]),
      .i_we    (1'b0),
      .i_waddr ('0),
      .i_wdata (32'd0),
      .o_inst  (w_inst)
   );

   assign w_op    = w_inst[31:26];
   assign w_rs    = w_inst[25:21];
   assign w_rt    = w_inst[20:16];
   assign w_rd    = w_inst[15:11];
   assign w_shamt = w_inst[10:6];
   assign w_funct = w_inst[5:0];

   cpu_control_rtype_br BR (
      .i_clk   (clk_CPU),
      .i_we    (w_reg_write),
      .i_rs    (w_rs),
      .i_rt    (w_rt),
      .i_rd    (w_rd),
      .i_wdata (w_alu),
      .o_a     (w_a),
      .o_b     (w_b)
   );

`ifndef CPU_SHIFT_EN
   logic w_unused_shamt;
   assign w_unused_shamt = ^w_shamt;
`endif

   always_comb begin
      w_supported = 1'b0;
      w_alu       = 32'd0;
      if (w_op == 6'd0) begin
         w_supported = 1'b1;
         case (w_funct)
            6'h20, 6'h21: w_alu = w_a + w_b;
            6'h22, 6'h23: w_alu = w_a - w_b;
            6'h24:        w_alu = w_a & w_b;
            6'h25:        w_alu = w_a | w_b;
            6'h26:        w_alu = w_a ^ w_b;
            6'h27:        w_alu = ~(w_a | w_b);
            6'h2A:        w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            6'h2B:        w_alu = {31'd0, w_a < w_b};
`ifdef CPU_SHIFT_EN
            6'h00:        w_alu = w_b << w_shamt;
            6'h02:        w_alu = w_b >> w_shamt;
            6'h03:        w_alu = $unsigned($signed(w_b) >>> w_shamt);
`endif
            default:      w_supported = 1'b0;
         endcase
      end
   end

   // Reset masks both the observed result and the write-back of the in-flight instruction.
   assign w_reg_write = w_supported && !reset_CPU;
   assign resultado   = w_reg_write ? w_alu : 32'd0;
endmodule

// File: tb/tb_cpu_control_rtype.sv
// Randomized self-checking bench for cpu_control_rtype against an instruction-level model.
// Honours CPU_SHIFT_EN the same way as the design.

module tb_cpu_control_rtype;
   localparam int IM_DEPTH = 64;

   logic        clk_CPU = 1'b0;
   logic        reset_CPU;
   logic [31:0] resultado;

   int n_chk = 0;
   int n_bad = 0;

   logic [31:0] m_regs [0:31];
   logic [31:0] m_im   [0:IM_DEPTH-1];
   logic [31:0] m_pc;

   cpu_control_rtype #(.IM_DEPTH(IM_DEPTH)) dut (
      .clk_CPU   (clk_CPU),
      .reset_CPU (reset_CPU),
      .resultado (resultado)
   );

   always #5 clk_CPU = ~clk_CPU;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                         input int sh, input int fn);
      logic [31:0] w;
      w = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
      return w;
   endfunction

   task automatic model_exec(input logic [31:0] inst, output bit we,
                             output int rd, output logic [31:0] res);
      int op, rs, rt, sh, fn;
      logic [31:0] a, b;
      op = int'(inst >> 26);
      rs = int'((inst >> 21) & 31);
      rt = int'((inst >> 16) & 31);
      rd = int'((inst >> 11) & 31);
      sh = int'((inst >> 6) & 31);
      fn = int'(inst & 63);
      a  = (rs == 0) ? 32'd0 : m_regs[rs];
      b  = (rt == 0) ? 32'd0 : m_regs[rt];
      we  = (op == 0);
      res = 32'd0;
      if (we) begin
         case (fn)
            'h20, 'h21: res = a + b;
            'h22, 'h23: res = a - b;
            'h24: res = a & b;
            'h25: res = a | b;
            'h26: res = a ^ b;
            'h27: res = ~(a | b);
            'h2A: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            'h2B: res = (a < b) ? 32'd1 : 32'd0;
`ifdef CPU_SHIFT_EN
            'h00: res = b << sh;
            'h02: res = b >> sh;
            'h03: res = 32'(int'(b) >>> sh);
`endif
            default: we = 1'b0;
         endcase
      end
      if (reset_CPU) begin
         we  = 1'b0;
         res = 32'd0;
      end
   endtask

   task automatic load_all();
      for (int i = 0; i < IM_DEPTH; i++) dut.IM.instBank[i] = m_im[i];
      for (int i = 0; i < 32; i++) dut.BR.registerBank[i] = m_regs[i];
      m_pc = 32'd0;
   endtask

   // Runs n cycles starting just after a negedge; optionally pulses reset mid-cycle at rst_at.
   task automatic run_cycles(input int n, input int rst_at);
      bit          we;
      int          rd;
      logic [31:0] res;
      for (int c = 0; c < n; c++) begin
         model_exec(m_im[(m_pc / 4) % IM_DEPTH], we, rd, res);
         chk("resultado", resultado, res);
         if (c == rst_at) begin
            reset_CPU = 1'b1;
            #1;
            chk("rst_resultado", resultado, 32'd0);
            @(posedge clk_CPU);
            #1;
            chk("rst_no_wb", dut.BR.registerBank[12], m_regs[12]);
            chk("rst_hold_res", resultado, 32'd0);
            @(negedge clk_CPU);
            reset_CPU = 1'b0;
            m_pc = 32'd0;
            #1;
         end else begin
            @(posedge clk_CPU);
            if (we && rd != 0) m_regs[rd] = res;
            m_pc = m_pc + 4;
            @(negedge clk_CPU);
            #1;
         end
      end
   endtask

   task automatic check_regs();
      for (int i = 1; i < 32; i++) chk($sformatf("reg%0d", i), dut.BR.registerBank[i], m_regs[i]);
   endtask

   function automatic logic [31:0] rand_inst(input int rd_lo);
      int fns [14] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h00, 'h02, 'h03, 0};
      int fn;
      logic [31:0] w;
      fn = fns[$urandom_range(0, 13)];
      if (fn == 0 && $urandom_range(0, 1) == 1) fn = int'($urandom_range(0, 63));
      w = rtype(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(rd_lo, 31)), int'($urandom_range(0, 31)), fn);
      if ($urandom_range(0, 7) == 0) w[31:26] = 6'($urandom_range(1, 63));
      return w;
   endfunction

   initial begin
      reset_CPU = 1'b1;

      // Round 0: directed program in words 0..15, random tail writing only $18..$31.
      for (int i = 0; i < 32; i++) m_regs[i] = $urandom;
      m_regs[0]  = 32'hDEAD0000;
      m_regs[1]  = 32'd5;
      m_regs[2]  = 32'd3;
      m_regs[7]  = 32'h77;
      m_regs[8]  = 32'h80000000;
      m_regs[9]  = 32'h99;
      m_regs[10] = 32'hF0F0F0F0;
      m_regs[11] = 32'h0FF00FF0;
      m_regs[12] = 32'h1212;
      m_regs[17] = 32'h1717;
      m_im[0]  = rtype(1, 2, 3, 0, 'h20);
      m_im[1]  = rtype(2, 1, 4, 0, 'h22);
      m_im[2]  = rtype(4, 1, 5, 0, 'h2A);
      m_im[3]  = rtype(4, 1, 6, 0, 'h2B);
      m_im[4]  = rtype(10, 11, 12, 0, 'h24);
      m_im[5]  = rtype(10, 11, 13, 0, 'h25);
      m_im[6]  = rtype(10, 11, 14, 0, 'h26);
      m_im[7]  = rtype(10, 11, 15, 0, 'h27);
      m_im[8]  = rtype(1, 2, 0, 0, 'h20);
      m_im[9]  = rtype(0, 1, 16, 0, 'h21);
      m_im[10] = rtype(1, 2, 2, 0, 'h20) | 32'h20000000;
      m_im[11] = rtype(0, 1, 7, 4, 'h00);
      m_im[12] = rtype(0, 8, 9, 4, 'h03);
      m_im[13] = 32'h00000000;
      m_im[14] = rtype(0, 8, 17, 4, 'h02);
      m_im[15] = rtype(1, 2, 2, 0, 'h3F);
      for (int i = 16; i < IM_DEPTH; i++) m_im[i] = rand_inst(18);
      load_all();
      #1;
      chk("reset_resultado", resultado, 32'd0);
      @(negedge clk_CPU);
      reset_CPU = 1'b0;
      #1;
      chk("first_add", resultado, 32'd8);
      run_cycles(2 * IM_DEPTH + 2, 4);
      check_regs();
      chk("add_r3", dut.BR.registerBank[3], 32'd8);
      chk("sub_r4", dut.BR.registerBank[4], 32'hFFFFFFFE);
      chk("slt_r5", dut.BR.registerBank[5], 32'd1);
      chk("sltu_r6", dut.BR.registerBank[6], 32'd0);
      chk("and_r12", dut.BR.registerBank[12], 32'h00F000F0);
      chk("or_r13", dut.BR.registerBank[13], 32'hFFF0FFF0);
      chk("xor_r14", dut.BR.registerBank[14], 32'hFF00FF00);
      chk("nor_r15", dut.BR.registerBank[15], 32'h000F000F);
      chk("zero_src_r16", dut.BR.registerBank[16], 32'd5);
      chk("nop_r2", dut.BR.registerBank[2], 32'd3);
`ifdef CPU_SHIFT_EN
      chk("sll_r7", dut.BR.registerBank[7], 32'h50);
      chk("sra_r9", dut.BR.registerBank[9], 32'hF8000000);
      chk("srl_r17", dut.BR.registerBank[17], 32'h08000000);
`else
      chk("sll_r7", dut.BR.registerBank[7], 32'h77);
      chk("sra_r9", dut.BR.registerBank[9], 32'h99);
      chk("srl_r17", dut.BR.registerBank[17], 32'h1717);
`endif

      // Fully random rounds.
      for (int r = 0; r < 3; r++) begin
         reset_CPU = 1'b1;
         for (int i = 0; i < 32; i++) m_regs[i] = $urandom;
         for (int i = 0; i < IM_DEPTH; i++) m_im[i] = rand_inst(0);
         load_all();
         #1;
         chk("round_reset_res", resultado, 32'd0);
         @(negedge clk_CPU);
         reset_CPU = 1'b0;
         #1;
         run_cycles(IM_DEPTH + 1 + int'($urandom_range(0, 20)), -1);
         check_regs();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end
endmodule
